// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches 64-byte lines over Sysbus into a one-line buffer and
// streams 32-bit instructions with their PC to the decoder; redirects restart the stream.
module instr_fetch #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      instr_valid,
  output logic [31:0]               instr,
  output logic [63:0]               instr_pc,
  input  logic                      instr_ready,
  output logic [2:0]                fsm_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_FILL    = 3'd2;
  localparam logic [2:0] S_DELIVER = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;

  // Sysbus read command to the memory device: {READ, MEMORY, 8'b0}.
  localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG = BUS_TAG_WIDTH'(13'h1100);
  localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

  logic [2:0]  state;
  logic [63:0] pc;
  logic [63:0] req_addr;
  logic [2:0]  beat;
  logic        pending;
  logic [31:0] line_buf [2*LINE_BEATS];

  logic [63:0] redir_pc;
  logic [63:0] pc_next;
  logic        last_beat;
  logic        unused_bits;

  assign redir_pc    = {redirect_pc[63:2], 2'b00};
  assign pc_next     = pc + 64'd4;
  assign last_beat   = bus_respcyc && (beat == LAST_BEAT);
  assign unused_bits = ^{bus_resptag, entry[1:0], redirect_pc[1:0]};

  // Handshakes: a transfer happens on an edge where valid and ready (cyc/ack) are both high;
  // a producer holds its payload stable from raising valid until that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      pc       <= 64'd0;
      req_addr <= 64'd0;
      beat     <= 3'd0;
      pending  <= 1'b0;
      for (int i = 0; i < 2*LINE_BEATS; i++) line_buf[i] <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          pc       <= {entry[63:2], 2'b00};
          req_addr <= {entry[63:6], 6'b0};
          state    <= S_REQ;
        end
        S_REQ: begin
          // req_addr stays put: a redirect only changes where the next request goes.
          if (redirect_valid) begin
            pc      <= redir_pc;
            pending <= 1'b1;
          end
          if (bus_reqack) begin
            beat    <= 3'd0;
            pending <= 1'b0;
            state   <= (pending || redirect_valid) ? S_DISCARD : S_FILL;
          end
        end
        S_FILL: begin
          if (bus_respcyc) begin
            beat                    <= beat + 3'd1;
            line_buf[{beat, 1'b0}]  <= bus_resp[31:0];
            line_buf[{beat, 1'b1}]  <= bus_resp[63:32];
          end
          if (redirect_valid) begin
            pc <= redir_pc;
            if (last_beat) begin
              req_addr <= {redir_pc[63:6], 6'b0};
              state    <= S_REQ;
            end else begin
              state <= S_DISCARD;
            end
          end else if (last_beat) begin
            state <= S_DELIVER;
          end
        end
        S_DISCARD: begin
          if (bus_respcyc) beat <= beat + 3'd1;
          if (redirect_valid) pc <= redir_pc;
          if (last_beat) begin
            req_addr <= redirect_valid ? {redir_pc[63:6], 6'b0} : {pc[63:6], 6'b0};
            state    <= S_REQ;
          end
        end
        S_DELIVER: begin
          if (redirect_valid) begin
            pc       <= redir_pc;
            req_addr <= {redir_pc[63:6], 6'b0};
            state    <= S_REQ;
          end else if (instr_ready) begin
            pc <= pc_next;
            if (pc[5:2] == 4'hf) begin
              req_addr <= {pc_next[63:6], 6'b0};
              state    <= S_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fsm_state   = state;
  assign bus_reqcyc  = (state == S_REQ);
  assign bus_req     = req_addr;
  assign bus_reqtag  = bus_reqcyc ? READ_TAG : '0;
  assign bus_respack = ((state == S_FILL) || (state == S_DISCARD)) && bus_respcyc;
  assign instr_valid = (state == S_DELIVER);
  assign instr       = instr_valid ? line_buf[pc[5:2]] : 32'd0;
  assign instr_pc    = instr_valid ? pc : 64'd0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: randomized bus timing, ready and redirects checked every cycle
// against a stream-level model of the PC sequence and request addresses.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  fsm_state;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .reset(reset), .entry(entry),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] req_log[$];
  logic [63:0] deliv_log[$];
  logic [63:0] exp_q[$];

  int ready_mode = 0;
  bit bus_hold = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model / compare (negedge) ----------------
  bit          started = 0;
  logic [63:0] model_pc;
  bit          expect_req, expect_invalid, expect_valid;
  bit          req_active, fill_active, redir_since_req;
  int          mbeats;
  logic [63:0] req_line;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check64("reset_reqcyc", bus_reqcyc, 0);
      check64("reset_instr_valid", instr_valid, 0);
      check64("reset_respack", bus_respack, 0);
      check64("reset_instr_pc", instr_pc, 0);
      check64("reset_bus_req", bus_req, 0);
      started = 0; expect_req = 0; expect_invalid = 0; expect_valid = 0;
      req_active = 0; fill_active = 0; redir_since_req = 0; mbeats = 0;
      continue;
    end
    if (!started) begin
      started = 1;
      model_pc = {entry[63:2], 2'b00};
      expect_req = 1;
      check64("idle_reqcyc", bus_reqcyc, 0);
      check64("idle_instr_valid", instr_valid, 0);
      continue;
    end
    if (expect_req) begin check64("req_timing", bus_reqcyc, 1); expect_req = 0; end
    if (expect_invalid) begin check64("valid_drop", instr_valid, 0); expect_invalid = 0; end
    if (expect_valid) begin check64("fill_to_valid", instr_valid, 1); expect_valid = 0; end
    if (req_active && !bus_reqcyc) check64("req_held", bus_reqcyc, 1);
    if (bus_reqcyc) begin
      if (!req_active) begin
        req_active = 1;
        req_line = {model_pc[63:6], 6'b0};
        redir_since_req = 0;
        req_log.push_back(req_line);
      end
      check64("req_addr", bus_req, req_line);
      check64("req_tag", bus_reqtag, 13'h1100);
      check64("req_during_fill", fill_active, 0);
    end
    if (instr_valid) begin
      check64("instr_pc", instr_pc, model_pc);
      check64("instr_word", instr, instr_pc[31:0]);
      check64("valid_while_busy", req_active || fill_active, 0);
    end
    check64("respack", bus_respack, fill_active && bus_respcyc);
    // advance the model to what the coming edge must do
    if (bus_reqcyc && bus_reqack) begin
      req_active = 0; fill_active = 1; mbeats = 0;
    end
    if (fill_active && bus_respcyc && bus_respack) begin
      mbeats++;
      if (mbeats == 8) begin
        fill_active = 0;
        if (!redir_since_req && !redirect_valid) expect_valid = 1;
        else expect_req = 1;
      end
    end
    if (redirect_valid) begin
      model_pc = {redirect_pc[63:2], 2'b00};
      expect_invalid = 1;
      redir_since_req = 1;
      if (instr_valid) expect_req = 1;
    end else if (instr_valid && instr_ready) begin
      deliv_log.push_back(instr_pc);
      if (model_pc[5:2] == 4'hf) begin expect_invalid = 1; expect_req = 1; end
      model_pc = model_pc + 64'd4;
    end
  end

  // ---------------- bus slave ----------------
  int          bphase = 0;
  int          bbeat = 0;
  logic [63:0] baddr;
  logic        n_ack, n_cyc;
  logic [63:0] n_resp;

  initial begin
    bus_reqack = 0; bus_respcyc = 0; bus_resp = 0; bus_resptag = 0;
    forever begin
      @(negedge clk);
      n_ack = 0; n_cyc = 0; n_resp = 0;
      if (!reset) begin
        bphase = 0;
      end else begin
        if (bphase == 0 && bus_reqcyc) begin
          if (bus_reqack) begin
            baddr = bus_req; bphase = 1; bbeat = 0;
          end else begin
            n_ack = ($urandom_range(0, 2) != 0);
          end
        end else if (bphase == 1 && bus_respcyc && bus_respack) begin
          bbeat++;
          if (bbeat == 8) bphase = 0;
        end
        if (bphase == 1 && !bus_hold && $urandom_range(0, 3) != 0) begin
          n_cyc = 1;
          n_resp = {32'(baddr + 64'(8*bbeat + 4)), 32'(baddr + 64'(8*bbeat))};
        end
      end
      @(posedge clk); #1;
      bus_reqack = n_ack; bus_respcyc = n_cyc; bus_resp = n_resp;
      bus_resptag = 13'($urandom);
    end
  end

  // ---------------- ready driver ----------------
  int ph = 0;
  initial begin
    instr_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: instr_ready = 1;
        1: begin instr_ready = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
        default: instr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start(input logic [63:0] e);
    reset = 0; entry = e; redirect_valid = 0; bus_hold = 0;
    cyc(3);
    req_log.delete(); deliv_log.delete();
    reset = 1;
  endtask

  task automatic wait_logs(input int nreq, input int ndel, input string name);
    int budget = 600;
    while ((req_log.size() < nreq || deliv_log.size() < ndel) && budget > 0) begin
      cyc(1); budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got req=%0d deliv=%0d expected req=%0d deliv=%0d",
               name, req_log.size(), deliv_log.size(), nreq, ndel);
    end
  endtask

  task automatic wait_beats(input int n, input string name);
    int budget = 300;
    while (!(fill_active && mbeats >= n) && budget > 0) begin cyc(1); budget--; end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got beats=%0d expected %0d", name, mbeats, n);
    end
  endtask

  task automatic redirect(input logic [63:0] target);
    redirect_valid = 1; redirect_pc = target;
    cyc(1);
    redirect_valid = 0;
  endtask

  initial begin
    reset = 0; entry = 0; redirect_valid = 0; redirect_pc = 0;

    // full line from 0x1000
    ready_mode = 0;
    start(64'h1000);
    wait_logs(2, 16, "line");
    for (int i = 0; i < 16; i++) exp_q.push_back(64'h1000 + 64'(4*i));
    check64("line_req0", req_log[0], 64'h1000);
    check64("line_req1", req_log[1], 64'h1040);
    check64("line_count", deliv_log.size(), 16);
    for (int i = 0; i < 16; i++) check64("line_pc", deliv_log[i], exp_q.pop_front());

    // mid-line entry
    start(64'h1038);
    wait_logs(2, 2, "midline");
    check64("mid_req0", req_log[0], 64'h1000);
    check64("mid_pc0", deliv_log[0], 64'h1038);
    check64("mid_pc1", deliv_log[1], 64'h103c);
    check64("mid_req1", req_log[1], 64'h1040);

    // ready stalls 1,0,0,1
    ready_mode = 1;
    start(64'h1000);
    wait_logs(2, 16, "stall");
    for (int i = 0; i < 16; i++) check64("stall_pc", deliv_log[i], 64'h1000 + 64'(4*i));
    ready_mode = 0;

    // redirect during fill
    start(64'h1000);
    wait_beats(3, "fill_redir");
    redirect(64'h2006);
    wait_logs(2, 1, "fill_redir");
    check64("fillredir_req1", req_log[1], 64'h2000);
    check64("fillredir_pc0", deliv_log[0], 64'h2004);

    // redirect wins over a handshake at 0x1010
    start(64'h1000);
    begin
      int budget = 300;
      while (!(instr_valid && instr_pc == 64'h1010) && budget > 0) begin cyc(1); budget--; end
      check64("hs_redir_reached", budget > 0, 1);
    end
    redirect(64'h3000);
    wait_logs(2, 5, "hs_redir");
    check64("hsredir_req1", req_log[1], 64'h3000);
    check64("hsredir_pc4", deliv_log[4], 64'h3000);
    foreach (deliv_log[i]) if (deliv_log[i] == 64'h1014) check64("hsredir_no1014", deliv_log[i], 64'h3000);

    // two redirects while discarding
    start(64'h1000);
    wait_beats(2, "discard");
    bus_hold = 1;
    cyc(2);
    redirect(64'h4000);
    redirect(64'h5000);
    bus_hold = 0;
    wait_logs(2, 1, "discard");
    check64("discard_req1", req_log[1], 64'h5000);
    check64("discard_pc0", deliv_log[0], 64'h5000);

    // 64-bit wrap of the next-line address
    start(64'hffff_ffff_ffff_fff8);
    wait_logs(2, 2, "wrap");
    check64("wrap_req0", req_log[0], 64'hffff_ffff_ffff_ffc0);
    check64("wrap_pc1", deliv_log[1], 64'hffff_ffff_ffff_fffc);
    check64("wrap_req1", req_log[1], 64'h0);

    // reset in the middle of a fill
    start(64'h1000);
    wait_beats(3, "midfill_reset");
    start(64'h1800);
    wait_logs(1, 1, "midfill_reset");
    check64("rst_req0", req_log[0], 64'h1800);
    check64("rst_pc0", deliv_log[0], 64'h1800);

    // randomized traffic
    ready_mode = 2;
    for (int r = 0; r < 3; r++) begin
      start({$urandom, $urandom});
      for (int c = 0; c < 1200; c++) begin
        if (c > 4 && $urandom_range(0, 40) == 0) begin
          case ($urandom_range(0, 2))
            0: redirect_pc = {$urandom, $urandom};
            1: redirect_pc = 64'h1000 + 64'($urandom_range(0, 255));
            default: redirect_pc = 64'hffff_ffff_ffff_ff80 + 64'($urandom_range(0, 127));
          endcase
          redirect_valid = 1;
        end else begin
          redirect_valid = 0;
        end
        cyc(1);
      end
      redirect_valid = 0;
      check64("random_progress", deliv_log.size() > 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
